// File: rtl/pause_ctrl_v2.sv
// pause_ctrl_v2: merges pause sources, the toggle button and the OSD into one pause state, with optional
// vblank-aligned entry, single-frame advance and a staged RGB dim after an idle period.
// Ports:
//   i_clk_sys        core system clock
//   i_reset_n        synchronous reset, active-low
//   i_user_button    pause toggle, rising edge acts
//   i_step_button    frame advance, rising edge acts (only while paused)
//   i_pause_request  per-source pause requests; i_src_mask enables each source
//   i_options        [0] pause while OSD open, [1] dim enable, [2] align pause entry to vblank
//   i_osd_status     OSD open
//   i_hs/vs/hb/vb, i_r/g/b   video in
//   o_pause_cpu      CPU halt
//   o_dim_level      current dim shift, 0 = none
//   o_hs/vs/hb/vb    syncs delayed one cycle
//   o_rgb            {r,g,b} each shifted right by the dim level, one cycle latency
module pause_ctrl_v2 #(
    parameter int RW        = 8,
    parameter int GW        = 8,
    parameter int BW        = 8,
    parameter int CLKSPD    = 12,
    parameter int NSRC      = 4,
    parameter int DIM_MS    = 10000,
    parameter int FADE_MS   = 500,
    parameter int MAX_SHIFT = 3
) (
    input  logic                  i_clk_sys,
    input  logic                  i_reset_n,
    input  logic                  i_user_button,
    input  logic                  i_step_button,
    input  logic [NSRC-1:0]       i_pause_request,
    input  logic [NSRC-1:0]       i_src_mask,
    input  logic [2:0]            i_options,
    input  logic                  i_osd_status,
    input  logic                  i_hs,
    input  logic                  i_vs,
    input  logic                  i_hb,
    input  logic                  i_vb,
    input  logic [RW-1:0]         i_r,
    input  logic [GW-1:0]         i_g,
    input  logic [BW-1:0]         i_b,
    output logic                  o_pause_cpu,
    output logic [2:0]            o_dim_level,
    output logic                  o_hs,
    output logic                  o_vs,
    output logic                  o_hb,
    output logic                  o_vb,
    output logic [RW+GW+BW-1:0]   o_rgb
);
    localparam int PRE = CLKSPD * 1000;
    localparam int PW  = $clog2(PRE);

    typedef enum logic [1:0] {RUN, PEND, PAUSED, STEP} state_t;

    state_t              r_state;
    logic                r_pause;
    logic                r_toggle;
    logic                r_user_last;
    logic                r_step_last;
    logic                r_vb_last;
    logic [PW-1:0]       r_presc;
    logic [31:0]         r_ms;
    logic [31:0]         r_fade;
    logic [2:0]          r_dim;
    logic                r_hs, r_vs, r_hb, r_vb;
    logic [RW+GW+BW-1:0] r_rgb;

    logic w_user_rise, w_step_rise, w_vb_rise, w_req, w_dim_on, w_tick;

    assign w_user_rise = i_user_button & ~r_user_last;
    assign w_step_rise = i_step_button & ~r_step_last;
    assign w_vb_rise   = i_vb & ~r_vb_last;
    assign w_req       = r_toggle | (|(i_pause_request & i_src_mask)) | (i_osd_status & i_options[0]);
    assign w_dim_on    = (r_state == PAUSED) & i_options[1];
    assign w_tick      = w_dim_on & (r_presc == PW'(PRE - 1));

    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n) begin
            r_user_last <= 1'b0;
            r_step_last <= 1'b0;
            r_vb_last   <= 1'b0;
            r_toggle    <= 1'b0;
        end else begin
            r_user_last <= i_user_button;
            r_step_last <= i_step_button;
            r_vb_last   <= i_vb;
            r_toggle    <= r_toggle ^ w_user_rise;
        end
    end

    // Dropping the request always wins over vblank/step so the CPU never stays halted without a cause.
    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n) begin
            r_state <= RUN;
            r_pause <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_req) begin
                        r_state <= i_options[2] ? PEND : PAUSED;
                        r_pause <= ~i_options[2];
                    end
                end
                PEND, STEP: begin
                    if (!w_req) begin
                        r_state <= RUN;
                        r_pause <= 1'b0;
                    end else if (w_vb_rise) begin
                        r_state <= PAUSED;
                        r_pause <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!w_req) begin
                        r_state <= RUN;
                        r_pause <= 1'b0;
                    end else if (w_step_rise) begin
                        r_state <= STEP;
                        r_pause <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_pause <= 1'b0;
                end
            endcase
        end
    end

    // Dim level steps on ms ticks: first step when the ms count reaches DIM_MS, then one per FADE_MS.
    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n || !w_dim_on) begin
            r_presc <= '0;
            r_ms    <= '0;
            r_fade  <= '0;
            r_dim   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_ms <= (r_ms == '1) ? r_ms : r_ms + 32'd1;
                if (r_dim == 3'd0) begin
                    if (r_ms + 32'd1 == 32'(DIM_MS))
                        r_dim <= 3'd1;
                end else if (r_dim < 3'(MAX_SHIFT)) begin
                    if (r_fade == 32'(FADE_MS - 1)) begin
                        r_dim  <= r_dim + 3'd1;
                        r_fade <= '0;
                    end else begin
                        r_fade <= r_fade + 32'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n) begin
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_hb  <= 1'b0;
            r_vb  <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_hs  <= i_hs;
            r_vs  <= i_vs;
            r_hb  <= i_hb;
            r_vb  <= i_vb;
            r_rgb <= {i_r >> r_dim, i_g >> r_dim, i_b >> r_dim};
        end
    end

    assign o_pause_cpu = r_pause;
    assign o_dim_level = r_dim;
    assign o_hs        = r_hs;
    assign o_vs        = r_vs;
    assign o_hb        = r_hb;
    assign o_vb        = r_vb;
    assign o_rgb       = r_rgb;
endmodule

// File: tb/tb_pause_ctrl_v2.sv
// tb_pause_ctrl_v2: scoreboard bench for pause_ctrl_v2 with short dim timing.
module tb_pause_ctrl_v2;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        user_button, step_button, osd;
    logic [3:0]  pause_request, src_mask;
    logic [2:0]  options;
    logic        hs, vs, hb, vb;
    logic [7:0]  r, g, b;
    logic        pause_cpu, hs_o, vs_o, hb_o, vb_o;
    logic [2:0]  dim_level;
    logic [23:0] rgb_out;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    pause_ctrl_v2 #(
        .RW(8), .GW(8), .BW(8), .CLKSPD(1), .NSRC(4),
        .DIM_MS(2), .FADE_MS(1), .MAX_SHIFT(3)
    ) dut (
        .i_clk_sys(clk), .i_reset_n(reset_n),
        .i_user_button(user_button), .i_step_button(step_button),
        .i_pause_request(pause_request), .i_src_mask(src_mask),
        .i_options(options), .i_osd_status(osd),
        .i_hs(hs), .i_vs(vs), .i_hb(hb), .i_vb(vb),
        .i_r(r), .i_g(g), .i_b(b),
        .o_pause_cpu(pause_cpu), .o_dim_level(dim_level),
        .o_hs(hs_o), .o_vs(vs_o), .o_hb(hb_o), .o_vb(vb_o),
        .o_rgb(rgb_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:       return {31'd0, pause_cpu};
            1:       return {29'd0, dim_level};
            2:       return {8'd0, rgb_out};
            default: return {28'd0, hs_o, vs_o, hb_o, vb_o};
        endcase
    endfunction

    // Compare every expectation due at this cycle, away from the active edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, obs(sb[i].sel), sb[i].v);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int d, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.cyc = cyc + d;
        e.sel = sel;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset_n = 1'b0; user_button = 1'b0; step_button = 1'b0; osd = 1'b0;
        pause_request = 4'b0; src_mask = 4'hF; options = 3'b0;
        hs = 1'b1; vs = 1'b1; hb = 1'b1; vb = 1'b0;
        r = 8'hFF; g = 8'hFF; b = 8'hFF;
        tick();
        expect_at(1, 0, 0, "rst_pause");
        expect_at(1, 1, 0, "rst_dim");
        expect_at(1, 2, 0, "rst_rgb");
        expect_at(1, 3, 0, "rst_sync");
        tick();
        reset_n = 1'b1;
        hs = 1'b0; vs = 1'b0; hb = 1'b0;
        r = 8'h00; g = 8'h00; b = 8'h00;
        tick(2);

        // source request, then mask it off
        pause_request = 4'b0100;
        expect_at(0, 0, 0, "t1_pre");
        expect_at(1, 0, 1, "t1_on");
        tick();
        src_mask = 4'b1011;
        expect_at(0, 0, 1, "t1_held");
        expect_at(1, 0, 0, "t1_masked");
        tick();
        pause_request = 4'b0; src_mask = 4'hF;
        tick(2);

        // user toggle on/off, then cancelled by reset
        user_button = 1'b1;
        expect_at(1, 0, 0, "t2_lat1");
        expect_at(2, 0, 1, "t2_on");
        tick();
        user_button = 1'b0;
        expect_at(3, 0, 1, "t2_hold");
        tick(3);
        user_button = 1'b1;
        expect_at(1, 0, 1, "t2_lat_off");
        expect_at(2, 0, 0, "t2_off");
        tick();
        user_button = 1'b0;
        tick(3);
        user_button = 1'b1;
        tick();
        user_button = 1'b0; reset_n = 1'b0;
        expect_at(1, 0, 0, "t2_in_rst");
        tick();
        reset_n = 1'b1;
        expect_at(1, 0, 0, "t2_rel");
        expect_at(3, 0, 0, "t2_after_rst");
        tick(4);

        // user edge while a source holds pause: toggle still flips
        pause_request = 4'b0100;
        tick(2);
        user_button = 1'b1;
        tick();
        user_button = 1'b0;
        tick();
        pause_request = 4'b0;
        expect_at(1, 0, 1, "t2b_toggle_hold");
        expect_at(3, 0, 1, "t2b_toggle_hold2");
        tick(4);
        user_button = 1'b1;
        expect_at(2, 0, 0, "t2b_release");
        tick();
        user_button = 1'b0;
        tick(3);

        // vblank-aligned entry
        options = 3'b100;
        pause_request = 4'b0100;
        expect_at(2, 0, 0, "t3_pend");
        expect_at(4, 0, 0, "t3_wait");
        tick(4);
        vb = 1'b1;
        expect_at(1, 0, 1, "t3_vb");
        tick();
        pause_request = 4'b0;
        expect_at(1, 0, 0, "t3_drop");
        tick(2);
        vb = 1'b0;
        tick();
        pause_request = 4'b0100;
        tick(2);
        pause_request = 4'b0; vb = 1'b1;
        expect_at(1, 0, 0, "t3_drop_vs_vb");
        expect_at(3, 0, 0, "t3_never");
        tick(3);
        vb = 1'b0;
        tick();

        // frame advance
        pause_request = 4'b0100;
        tick(2);
        vb = 1'b1;
        expect_at(1, 0, 1, "t4_paused");
        tick();
        vb = 1'b0;
        tick(2);
        step_button = 1'b1;
        expect_at(1, 0, 0, "t4_step");
        expect_at(3, 0, 0, "t4_step_run");
        tick();
        step_button = 1'b0;
        tick(3);
        vb = 1'b1;
        expect_at(0, 0, 0, "t4_pre_vb");
        expect_at(1, 0, 1, "t4_repause");
        tick();
        vb = 1'b0;
        tick(2);
        pause_request = 4'b0;
        expect_at(1, 0, 0, "t4_unpause");
        tick(2);
        options = 3'b000;
        step_button = 1'b1;
        tick();
        pause_request = 4'b0100;
        expect_at(1, 0, 1, "t4_run_step_pause");
        expect_at(3, 0, 1, "t4_run_step_ignored");
        tick(4);
        step_button = 1'b0; pause_request = 4'b0;
        tick(2);

        // staged dim
        options = 3'b010;
        r = 8'hF0; g = 8'h81; b = 8'h07;
        pause_request = 4'b0100;
        expect_at(1, 0, 1, "t5_paused");
        expect_at(2000, 1, 0, "t5_pre_l1");
        expect_at(2001, 1, 1, "t5_l1");
        expect_at(3000, 1, 1, "t5_pre_l2");
        expect_at(3001, 1, 2, "t5_l2");
        expect_at(4001, 1, 3, "t5_l3");
        expect_at(4001, 2, 24'h3C2001, "t5_rgb_l2");
        expect_at(4002, 2, 24'h1E1000, "t5_rgb_l3");
        expect_at(6000, 1, 3, "t5_sat");
        expect_at(6001, 2, 24'h1E1000, "t5_rgb_sat");
        tick(6005);
        pause_request = 4'b0;
        expect_at(1, 0, 0, "t5_unpause");
        expect_at(2, 1, 0, "t5_dim_clear");
        expect_at(3, 2, 24'hF08107, "t5_rgb_clear");
        tick(4);
        options = 3'b000;

        // video pass-through, one cycle delay
        for (int i = 0; i < 20; i++) begin
            hs = ~hs; vs = ~vs; hb = ~hb; vb = ~vb;
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            expect_at(1, 3, {28'd0, hs, vs, hb, vb}, "t6_sync");
            expect_at(1, 2, {8'd0, r, g, b}, "t6_rgb");
            tick();
        end
        tick(3);
        chk("drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
